// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage
//
// Execute stage of a 5-stage ARM-style pipeline. It consumes the outputs of
// the ID/EX pipeline register, builds the second ALU operand (Val2), runs the
// ALU, owns the NZCV status register and computes the branch target. Results
// are captured in the EX/MEM boundary register, so MEM sees them one cycle
// after they enter this stage.
//
// Ports
//   clk                     : clock, rising edge active
//   rst                     : asynchronous reset, active low
//   freeze                  : memory stall, holds EX/MEM outputs and status
//   flush                   : turns the current instruction into a bubble
//   pc_in                   : PC+4 of the instruction in EX
//   mem_read_en_in          : LDR
//   mem_write_en_in         : STR
//   wb_enable_in            : register writeback
//   immediate_in            : I bit (rotated 8-bit immediate operand)
//   branch_taken_in         : B instruction
//   status_write_enable_in  : S bit
//   execute_command_in      : ALU operation code
//   val_rn_in               : Rn value
//   val_rm_in               : Rm value, also the STR data
//   dest_reg_in             : Rd
//   signed_immediate_in     : 24-bit branch word offset
//   shift_operand_in        : 12-bit shifter operand field
//   alu_result_out          : registered ALU result / memory address
//   st_val_out              : registered store data
//   dest_reg_out            : registered Rd
//   wb_enable_out           : registered writeback enable
//   mem_read_en_out         : registered memory read enable
//   mem_write_en_out        : registered memory write enable
//   branch_taken_out        : combinational branch request to IF / hazard unit
//   branch_addr_out         : combinational branch target
//   status_out              : registered {N,Z,C,V}
// ----------------------------------------------------------------------------
module exe_stage #(
    parameter int WORD_LEN     = 32,
    parameter int CMD_LEN      = 4,
    parameter int REG_ADDR_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic [WORD_LEN-1:0]     pc_in,
    input  logic                    mem_read_en_in,
    input  logic                    mem_write_en_in,
    input  logic                    wb_enable_in,
    input  logic                    immediate_in,
    input  logic                    branch_taken_in,
    input  logic                    status_write_enable_in,
    input  logic [CMD_LEN-1:0]      execute_command_in,
    input  logic [WORD_LEN-1:0]     val_rn_in,
    input  logic [WORD_LEN-1:0]     val_rm_in,
    input  logic [REG_ADDR_LEN-1:0] dest_reg_in,
    input  logic [23:0]             signed_immediate_in,
    input  logic [11:0]             shift_operand_in,
    output logic [WORD_LEN-1:0]     alu_result_out,
    output logic [WORD_LEN-1:0]     st_val_out,
    output logic [REG_ADDR_LEN-1:0] dest_reg_out,
    output logic                    wb_enable_out,
    output logic                    mem_read_en_out,
    output logic                    mem_write_en_out,
    output logic                    branch_taken_out,
    output logic [WORD_LEN-1:0]     branch_addr_out,
    output logic [3:0]              status_out
);

    // ALU operation codes
    localparam logic [CMD_LEN-1:0] CMD_MOV = CMD_LEN'(4'b0001);
    localparam logic [CMD_LEN-1:0] CMD_MVN = CMD_LEN'(4'b1001);
    localparam logic [CMD_LEN-1:0] CMD_ADD = CMD_LEN'(4'b0010);
    localparam logic [CMD_LEN-1:0] CMD_ADC = CMD_LEN'(4'b0011);
    localparam logic [CMD_LEN-1:0] CMD_SUB = CMD_LEN'(4'b0100);
    localparam logic [CMD_LEN-1:0] CMD_SBC = CMD_LEN'(4'b0101);
    localparam logic [CMD_LEN-1:0] CMD_AND = CMD_LEN'(4'b0110);
    localparam logic [CMD_LEN-1:0] CMD_ORR = CMD_LEN'(4'b0111);
    localparam logic [CMD_LEN-1:0] CMD_EOR = CMD_LEN'(4'b1000);

    // Shift type encodings from shift_operand_in[6:5]
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Width wide enough to hold WORD_LEN itself as a shift distance
    localparam int SHW = $clog2(WORD_LEN) + 1;

    localparam logic [WORD_LEN:0] ONE_EXT = {{WORD_LEN{1'b0}}, 1'b1};

    // Registered NZCV flags
    logic [3:0] status_reg;
    logic       c_flag;
    logic       v_flag;

    // Operand generation
    logic [WORD_LEN-1:0] val2;
    logic [WORD_LEN-1:0] imm_ext;
    logic [4:0]          imm_rot;
    logic [4:0]          shift_amt;
    logic [1:0]          shift_type;
    logic [WORD_LEN-1:0] shifted_rm;

    // ALU
    logic [WORD_LEN:0]   sum_ext;
    logic [WORD_LEN-1:0] alu_result;
    logic                carry_new;
    logic                overflow_new;
    logic                negative_new;
    logic                zero_new;

    logic [WORD_LEN-1:0] branch_offset;

    assign c_flag = status_reg[1];
    assign v_flag = status_reg[0];

    // Rotate right by 0..31. A zero distance makes the left-shift term shift
    // by the full word width, which yields zero, so the value passes through.
    function automatic logic [WORD_LEN-1:0] rotate_right(
        input logic [WORD_LEN-1:0] value,
        input logic [4:0]          amount
    );
        logic [SHW-1:0] back_amount;
        back_amount = SHW'(WORD_LEN) - {{(SHW-5){1'b0}}, amount};
        return (value >> amount) | (value << back_amount);
    endfunction

    assign imm_ext    = {{(WORD_LEN-8){1'b0}}, shift_operand_in[7:0]};
    assign imm_rot    = {shift_operand_in[11:8], 1'b0};
    assign shift_amt  = shift_operand_in[11:7];
    assign shift_type = shift_operand_in[6:5];

    // Register-operand shifter; every type with a zero amount is a plain pass
    always_comb begin
        shifted_rm = val_rm_in;
        case (shift_type)
            SHIFT_LSL: shifted_rm = val_rm_in << shift_amt;
            SHIFT_LSR: shifted_rm = val_rm_in >> shift_amt;
            SHIFT_ASR: shifted_rm = $unsigned($signed(val_rm_in) >>> shift_amt);
            SHIFT_ROR: shifted_rm = rotate_right(val_rm_in, shift_amt);
            default:   shifted_rm = val_rm_in;
        endcase
    end

    // Val2 select: memory ops use the raw 12-bit offset even if the I bit is
    // set, because load/store address offsets are never rotated
    always_comb begin
        val2 = shifted_rm;
        if (mem_read_en_in || mem_write_en_in) begin
            val2 = {{(WORD_LEN-12){1'b0}}, shift_operand_in};
        end else if (immediate_in) begin
            val2 = rotate_right(imm_ext, imm_rot);
        end
    end

    // ALU. Subtraction is done as Rn + ~Val2 + carry_in so that bit WORD_LEN
    // of the extended sum is directly the ARM "not borrow" carry. Logic and
    // move ops leave C and V as they were in the status register.
    always_comb begin
        sum_ext      = '0;
        alu_result   = '0;
        carry_new    = c_flag;
        overflow_new = v_flag;
        case (execute_command_in)
            CMD_MOV: alu_result = val2;
            CMD_MVN: alu_result = ~val2;
            CMD_ADD: begin
                sum_ext      = {1'b0, val_rn_in} + {1'b0, val2};
                alu_result   = sum_ext[WORD_LEN-1:0];
                carry_new    = sum_ext[WORD_LEN];
                overflow_new = (val_rn_in[WORD_LEN-1] == val2[WORD_LEN-1]) &&
                               (alu_result[WORD_LEN-1] != val_rn_in[WORD_LEN-1]);
            end
            CMD_ADC: begin
                sum_ext      = {1'b0, val_rn_in} + {1'b0, val2} +
                               {{WORD_LEN{1'b0}}, c_flag};
                alu_result   = sum_ext[WORD_LEN-1:0];
                carry_new    = sum_ext[WORD_LEN];
                overflow_new = (val_rn_in[WORD_LEN-1] == val2[WORD_LEN-1]) &&
                               (alu_result[WORD_LEN-1] != val_rn_in[WORD_LEN-1]);
            end
            CMD_SUB: begin
                sum_ext      = {1'b0, val_rn_in} + {1'b0, ~val2} + ONE_EXT;
                alu_result   = sum_ext[WORD_LEN-1:0];
                carry_new    = sum_ext[WORD_LEN];
                overflow_new = (val_rn_in[WORD_LEN-1] != val2[WORD_LEN-1]) &&
                               (alu_result[WORD_LEN-1] != val_rn_in[WORD_LEN-1]);
            end
            CMD_SBC: begin
                sum_ext      = {1'b0, val_rn_in} + {1'b0, ~val2} +
                               {{WORD_LEN{1'b0}}, c_flag};
                alu_result   = sum_ext[WORD_LEN-1:0];
                carry_new    = sum_ext[WORD_LEN];
                overflow_new = (val_rn_in[WORD_LEN-1] != val2[WORD_LEN-1]) &&
                               (alu_result[WORD_LEN-1] != val_rn_in[WORD_LEN-1]);
            end
            CMD_AND: alu_result = val_rn_in & val2;
            CMD_ORR: alu_result = val_rn_in | val2;
            CMD_EOR: alu_result = val_rn_in ^ val2;
            default: alu_result = '0;
        endcase
    end

    assign negative_new = alu_result[WORD_LEN-1];
    assign zero_new     = (alu_result == '0);

    // Branch target: word offset sign-extended and scaled to bytes
    assign branch_offset    = {{(WORD_LEN-26){signed_immediate_in[23]}},
                               signed_immediate_in, 2'b00};
    assign branch_addr_out  = pc_in + branch_offset;
    assign branch_taken_out = branch_taken_in && !flush;

    // Status register: a stalled or flushed instruction must not touch flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_reg <= 4'b0000;
        end else if (status_write_enable_in && !freeze && !flush) begin
            status_reg <= {negative_new, zero_new, carry_new, overflow_new};
        end
    end

    assign status_out = status_reg;

    // EX/MEM boundary register: freeze holds everything, flush inserts a
    // bubble with all fields cleared, otherwise the instruction advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_out   <= '0;
            st_val_out       <= '0;
            dest_reg_out     <= '0;
            wb_enable_out    <= 1'b0;
            mem_read_en_out  <= 1'b0;
            mem_write_en_out <= 1'b0;
        end else if (freeze) begin
            alu_result_out   <= alu_result_out;
            st_val_out       <= st_val_out;
            dest_reg_out     <= dest_reg_out;
            wb_enable_out    <= wb_enable_out;
            mem_read_en_out  <= mem_read_en_out;
            mem_write_en_out <= mem_write_en_out;
        end else if (flush) begin
            alu_result_out   <= '0;
            st_val_out       <= '0;
            dest_reg_out     <= '0;
            wb_enable_out    <= 1'b0;
            mem_read_en_out  <= 1'b0;
            mem_write_en_out <= 1'b0;
        end else begin
            alu_result_out   <= alu_result;
            st_val_out       <= val_rm_in;
            dest_reg_out     <= dest_reg_in;
            wb_enable_out    <= wb_enable_in;
            mem_read_en_out  <= mem_read_en_in;
            mem_write_en_out <= mem_write_en_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// ----------------------------------------------------------------------------
// tb_exe_stage
//
// Directed self-checking bench for exe_stage. Each directed step drives one
// instruction on a falling edge and pushes the hand-derived EX/MEM contents
// expected after the next rising edge onto a scoreboard queue; the entry is
// popped and compared on the following falling edge. Combinational branch
// outputs and the asynchronous reset are checked directly.
// ----------------------------------------------------------------------------
module tb_exe_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [3:0]  status;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] pc_in;
    logic        mem_read_en_in;
    logic        mem_write_en_in;
    logic        wb_enable_in;
    logic        immediate_in;
    logic        branch_taken_in;
    logic        status_write_enable_in;
    logic [3:0]  execute_command_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic [3:0]  dest_reg_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic [31:0] alu_result_out;
    logic [31:0] st_val_out;
    logic [3:0]  dest_reg_out;
    logic        wb_enable_out;
    logic        mem_read_en_out;
    logic        mem_write_en_out;
    logic        branch_taken_out;
    logic [31:0] branch_addr_out;
    logic [3:0]  status_out;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    exe_stage #(
        .WORD_LEN(32),
        .CMD_LEN(4),
        .REG_ADDR_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .flush(flush),
        .pc_in(pc_in),
        .mem_read_en_in(mem_read_en_in),
        .mem_write_en_in(mem_write_en_in),
        .wb_enable_in(wb_enable_in),
        .immediate_in(immediate_in),
        .branch_taken_in(branch_taken_in),
        .status_write_enable_in(status_write_enable_in),
        .execute_command_in(execute_command_in),
        .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in),
        .dest_reg_in(dest_reg_in),
        .signed_immediate_in(signed_immediate_in),
        .shift_operand_in(shift_operand_in),
        .alu_result_out(alu_result_out),
        .st_val_out(st_val_out),
        .dest_reg_out(dest_reg_out),
        .wb_enable_out(wb_enable_out),
        .mem_read_en_out(mem_read_en_out),
        .mem_write_en_out(mem_write_en_out),
        .branch_taken_out(branch_taken_out),
        .branch_addr_out(branch_addr_out),
        .status_out(status_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL timeout reached before end of sequence");
        $fatal(1, "[TB] timeout");
    end

    function automatic exp_t mkExp(input logic [31:0] alu, input logic [31:0] st,
                                   input logic [3:0] dest, input logic wb,
                                   input logic mr, input logic mw,
                                   input logic [3:0] status);
        exp_t e;
        e.alu    = alu;
        e.st     = st;
        e.dest   = dest;
        e.wb     = wb;
        e.mr     = mr;
        e.mw     = mw;
        e.status = status;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one instruction; freeze, flush and branch inputs are left alone
    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] rn,
                                 input logic [31:0] rm, input logic imm,
                                 input logic [11:0] shop, input logic s,
                                 input logic wb, input logic mr, input logic mw,
                                 input logic [3:0] dest);
        execute_command_in     = cmd;
        val_rn_in              = rn;
        val_rm_in              = rm;
        immediate_in           = imm;
        shift_operand_in       = shop;
        status_write_enable_in = s;
        wb_enable_in           = wb;
        mem_read_en_in         = mr;
        mem_write_en_in        = mw;
        dest_reg_in            = dest;
    endtask

    task automatic checkAllOutputs(input string tag, input exp_t e);
        checkOutput({tag, ".alu"},    alu_result_out,            e.alu);
        checkOutput({tag, ".st"},     st_val_out,                e.st);
        checkOutput({tag, ".dest"},   32'(dest_reg_out),         32'(e.dest));
        checkOutput({tag, ".wb"},     32'(wb_enable_out),        32'(e.wb));
        checkOutput({tag, ".mr"},     32'(mem_read_en_out),      32'(e.mr));
        checkOutput({tag, ".mw"},     32'(mem_write_en_out),     32'(e.mw));
        checkOutput({tag, ".status"}, 32'(status_out),           32'(e.status));
    endtask

    // One rising edge, then compare on the falling edge against the queue head
    task automatic clockAndCheck(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s scoreboard empty observed=%h expected=entry", tag,
                   alu_result_out);
        end else begin
            e = exp_q.pop_front();
            checkAllOutputs(tag, e);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst                 = 1'b0;
        freeze              = 1'b0;
        flush               = 1'b0;
        pc_in               = 32'h0;
        branch_taken_in     = 1'b0;
        signed_immediate_in = 24'h0;
        applyStimulus(4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Reset state
        #2;
        checkAllOutputs("reset", mkExp(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
        @(negedge clk);
        rst = 1'b1;

        // ADD 0xFFFFFFFF + imm 1 -> 0, Z and C set
        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 12'h001, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd3);
        exp_q.push_back(mkExp(32'h0, 32'h1234_5678, 4'd3, 1'b1, 1'b0, 1'b0, 4'b0110));
        clockAndCheck("add_wrap");

        // SUB 0x80000000 - (Rm LSL #0 = 1) -> 0x7FFFFFFF, C and V set
        applyStimulus(4'b0100, 32'h8000_0000, 32'h1, 1'b0, 12'h000, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd4);
        exp_q.push_back(mkExp(32'h7FFF_FFFF, 32'h1, 4'd4, 1'b1, 1'b0, 1'b0, 4'b0011));
        clockAndCheck("sub_ovf");

        // ADC uses registered C=1: 5 + 2 + 1, flags untouched (S=0)
        applyStimulus(4'b0011, 32'h5, 32'h0, 1'b1, 12'h002, 1'b0,
                      1'b1, 1'b0, 1'b0, 4'd5);
        exp_q.push_back(mkExp(32'h8, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 4'b0011));
        clockAndCheck("adc_carry");

        // MOV imm 0xFF ROR 8 -> 0xFF000000, N set, C/V kept
        applyStimulus(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd6);
        exp_q.push_back(mkExp(32'hFF00_0000, 32'h0, 4'd6, 1'b1, 1'b0, 1'b0, 4'b1011));
        clockAndCheck("mov_rot_imm");

        // MOV Rm ASR #4 of 0x80000000 -> 0xF8000000
        applyStimulus(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b0,
                      1'b1, 1'b0, 1'b0, 4'd6);
        exp_q.push_back(mkExp(32'hF800_0000, 32'h8000_0000, 4'd6, 1'b1, 1'b0, 1'b0,
                              4'b1011));
        clockAndCheck("mov_asr");

        // SUB 1 - 2 -> 0xFFFFFFFF with borrow (C=0)
        applyStimulus(4'b0100, 32'h1, 32'h2, 1'b0, 12'h000, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd1);
        exp_q.push_back(mkExp(32'hFFFF_FFFF, 32'h2, 4'd1, 1'b1, 1'b0, 1'b0, 4'b1000));
        clockAndCheck("sub_borrow");

        // SBC with C=0: 10 - 3 - 1 = 6, no borrow so C=1
        applyStimulus(4'b0101, 32'd10, 32'h0, 1'b1, 12'h003, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd2);
        exp_q.push_back(mkExp(32'h6, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 4'b0010));
        clockAndCheck("sbc");

        // LDR: address = Rn + zero-extended 12-bit offset
        applyStimulus(4'b0010, 32'h1000, 32'h0, 1'b0, 12'h804, 1'b0,
                      1'b1, 1'b1, 1'b0, 4'd8);
        exp_q.push_back(mkExp(32'h1804, 32'h0, 4'd8, 1'b1, 1'b1, 1'b0, 4'b0010));
        clockAndCheck("ldr");

        // STR with I bit set: offset still used raw, not rotated
        applyStimulus(4'b0010, 32'h20, 32'hDEAD_BEEF, 1'b1, 12'hF10, 1'b0,
                      1'b0, 1'b0, 1'b1, 4'd7);
        exp_q.push_back(mkExp(32'hF30, 32'hDEAD_BEEF, 4'd7, 1'b0, 1'b0, 1'b1, 4'b0010));
        clockAndCheck("str");

        // MVN of (0xF0 LSR #4) -> 0xFFFFFFF0, N set, C/V kept
        applyStimulus(4'b1001, 32'h0, 32'hF0, 1'b0, 12'h220, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd9);
        exp_q.push_back(mkExp(32'hFFFF_FFF0, 32'hF0, 4'd9, 1'b1, 1'b0, 1'b0, 4'b1010));
        clockAndCheck("mvn_lsr");

        // EOR
        applyStimulus(4'b1000, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 12'h000, 1'b0,
                      1'b1, 1'b0, 1'b0, 4'd10);
        exp_q.push_back(mkExp(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd10, 1'b1, 1'b0, 1'b0,
                              4'b1010));
        clockAndCheck("eor");

        // MOV Rm ROR #4 of 0xF -> 0xF0000000
        applyStimulus(4'b0001, 32'h0, 32'hF, 1'b0, 12'h260, 1'b0,
                      1'b1, 1'b0, 1'b0, 4'd11);
        exp_q.push_back(mkExp(32'hF000_0000, 32'hF, 4'd11, 1'b1, 1'b0, 1'b0, 4'b1010));
        clockAndCheck("mov_ror");

        // Undefined command code gives 0
        applyStimulus(4'b0000, 32'h5, 32'h3, 1'b0, 12'h000, 1'b0,
                      1'b1, 1'b0, 1'b0, 4'd2);
        exp_q.push_back(mkExp(32'h0, 32'h3, 4'd2, 1'b1, 1'b0, 1'b0, 4'b1010));
        clockAndCheck("undef_cmd");

        // Branch target and taken, then flush kills taken and the instruction
        applyStimulus(4'b0010, 32'h1, 32'h9, 1'b1, 12'h001, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd9);
        pc_in               = 32'h100;
        signed_immediate_in = 24'hFFFFFE;
        branch_taken_in     = 1'b1;
        #1;
        checkOutput("br_addr_neg", branch_addr_out, 32'h0000_00F8);
        checkOutput("br_taken", 32'(branch_taken_out), 32'h1);
        flush = 1'b1;
        #1;
        checkOutput("br_taken_flush", 32'(branch_taken_out), 32'h0);
        exp_q.push_back(mkExp(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1010));
        clockAndCheck("flush_bubble");
        flush           = 1'b0;
        branch_taken_in = 1'b0;

        // ADD 1 + 1 with flags cleared; also branch wrap and positive offset
        applyStimulus(4'b0010, 32'h1, 32'h55, 1'b1, 12'h001, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd9);
        pc_in               = 32'h4;
        signed_immediate_in = 24'hFFFFFE;
        #1;
        checkOutput("br_addr_wrap", branch_addr_out, 32'hFFFF_FFFC);
        checkOutput("br_not_taken", 32'(branch_taken_out), 32'h0);
        pc_in               = 32'h100;
        signed_immediate_in = 24'h000010;
        #1;
        checkOutput("br_addr_pos", branch_addr_out, 32'h0000_0140);
        exp_q.push_back(mkExp(32'h2, 32'h55, 4'd9, 1'b1, 1'b0, 1'b0, 4'b0000));
        clockAndCheck("add_small");

        // Freeze holds all outputs and status
        freeze = 1'b1;
        applyStimulus(4'b0010, 32'h100, 32'h66, 1'b1, 12'h005, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd10);
        exp_q.push_back(mkExp(32'h2, 32'h55, 4'd9, 1'b1, 1'b0, 1'b0, 4'b0000));
        clockAndCheck("freeze_hold");

        // Freeze together with flush: hold wins
        flush = 1'b1;
        exp_q.push_back(mkExp(32'h2, 32'h55, 4'd9, 1'b1, 1'b0, 1'b0, 4'b0000));
        clockAndCheck("freeze_flush_hold");

        // Release: held instruction appears after one edge
        freeze = 1'b0;
        flush  = 1'b0;
        exp_q.push_back(mkExp(32'h105, 32'h66, 4'd10, 1'b1, 1'b0, 1'b0, 4'b0000));
        clockAndCheck("freeze_release");

        // Signed overflow on ADD: 0x7FFFFFFF + 1
        applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd13);
        exp_q.push_back(mkExp(32'h8000_0000, 32'h0, 4'd13, 1'b1, 1'b0, 1'b0, 4'b1001));
        clockAndCheck("add_ovf");

        // Async reset between edges during an LDR
        applyStimulus(4'b0010, 32'h200, 32'h0, 1'b0, 12'h010, 1'b0,
                      1'b1, 1'b1, 1'b0, 4'd11);
        #2;
        rst = 1'b0;
        #1;
        checkAllOutputs("async_rst", mkExp(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
        @(posedge clk);
        @(negedge clk);
        checkAllOutputs("rst_held", mkExp(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
        rst = 1'b1;

        // First instruction after reset release appears after one edge
        applyStimulus(4'b0010, 32'h7, 32'h77, 1'b1, 12'h003, 1'b1,
                      1'b1, 1'b0, 1'b0, 4'd12);
        exp_q.push_back(mkExp(32'hA, 32'h77, 4'd12, 1'b1, 1'b0, 1'b0, 4'b0000));
        clockAndCheck("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Generates Val2 (rotated immediate, shifted register, or memory offset) and runs the ALU. Owns the NZCV status register.
- Computes the branch target and registers results into the EX/MEM boundary. MEM sees them one cycle later.

Parameters:
- WORD_LEN, 32, datapath and PC width
- CMD_LEN, 4, execute command width
- REG_ADDR_LEN, 4, destination register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  hold EX/MEM outputs and status register (memory stall)
- flush  in  1  turn the current instruction into a bubble
- pc_in  in  32  PC+4 of the instruction
- mem_read_en_in  in  1  LDR
- mem_write_en_in  in  1  STR
- wb_enable_in  in  1  register writeback
- immediate_in  in  1  I bit
- branch_taken_in  in  1  B instruction
- status_write_enable_in  in  1  S bit
- execute_command_in  in  4  ALU operation
- val_rn_in  in  32  Rn value
- val_rm_in  in  32  Rm value (also the STR data)
- dest_reg_in  in  4  Rd
- signed_immediate_in  in  24  branch offset
- shift_operand_in  in  12  shifter operand
- alu_result_out  out  32  registered ALU result / memory address
- st_val_out  out  32  registered store data
- dest_reg_out  out  4  registered Rd
- wb_enable_out, mem_read_en_out, mem_write_en_out  out  1 each  registered controls
- branch_taken_out  out  1  combinational, to IF and hazard flush
- branch_addr_out  out  32  combinational branch target
- status_out  out  4  {N,Z,C,V}, registered

Behaviour:
- Reset (rst=0, async): all registered outputs and status clear to 0. Reset asserted mid-instruction discards that instruction.
- Val2 generation:
  - Memory op (mem_read_en_in or mem_write_en_in): val2 = zero-extended shift_operand_in[11:0].
  - immediate_in=1: val2 = {24'b0, imm8} rotated right by 2*rot4. imm8 = shift_operand_in[7:0]; rot4 = [11:8].
  - Otherwise: val_rm_in shifted by shift_imm = [11:7] using type [6:5]. 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROR. A shift amount of 0 means no shift for all types.
- ALU commands:
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: Rn+val2
  - 0011 ADC: Rn+val2+C
  - 0100 SUB: Rn−val2
  - 0101 SBC: Rn−val2−!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code gives result 0.
  - CMP/TST/LDR/STR arrive as SUB/AND/ADD/ADD with wb_enable_in=0 as needed.
- Flags:
  - N = result[31].
  - Z = (result==0).
  - Add-type ops: C = bit 32 of the 33-bit sum; V = signed overflow.
  - Subtract-type ops: C = NOT borrow; V = signed overflow.
  - Logic and move ops keep the previous C and V.
- Status register:
  - Loads the new flags on a clock edge when status_write_enable_in=1 && !freeze && !flush.
  - The new value is visible on status_out the next cycle, and ADC/SBC use the registered C.
- Branch:
  - branch_addr_out = pc_in + (sign-extend(signed_immediate_in) << 2), wrap-around mod 2^32.
  - branch_taken_out = branch_taken_in && !flush, same cycle (combinational).
- EX/MEM register, latency 1:
  - Priority: freeze > flush > load. freeze holds every registered output and the status register. flush (without freeze) clears wb/mem_read/mem_write to 0 and leaves the data fields don't-care (cleared to 0).
  - Otherwise all fields load: st_val_out = val_rm_in, dest_reg_out = dest_reg_in.
- Arithmetic is modulo 2^32. No traps.

Test Plan:
- ADD with Rn=0xFFFFFFFF, MOV-immediate val2=1 (imm8=1, rot=0), S=1 → next cycle alu_result_out=0; status_out after the edge = 4'b0110 (Z=1, C=1).
- SUB with Rn=0x80000000, val2=1 (register LSL #0), S=1 → result 0x7FFFFFFF; status = 4'b0011 (C=1, V=1).
- Immediate imm8=0xFF, rot4=4 (ROR 8) with MOV → alu_result_out=0xFF000000; ASR #4 of Rm=0x80000000 → 0xF8000000.
- Branch with pc_in=0x100, imm24=0xFFFFFE → branch_addr_out=0x0F8 and branch_taken_out=1 in the same cycle; with flush=1, branch_taken_out=0.
- ADD with wb=1 at edge N while freeze=1 → outputs keep their previous values, status unchanged. Release freeze → result appears after the next edge. freeze and flush together → the hold wins.
- Assert rst=0 asynchronously between edges during an LDR → all outputs and status go to 0 immediately. After release, the first instruction appears after 1 edge.
